// File: rtl/box_pkg.sv
// Shared constants and the packing helper for the bounding-box stream blocks.
package box_pkg;

    // Default geometry for a packed box corner
    localparam int unsigned DEFAULT_COORD_W  = 16;
    localparam int unsigned DEFAULT_NUM_AXES = 3;

    // Axis numbering; axis 0 sits in the MSBs of every packed bus
    localparam int unsigned AXIS_X = 0;
    localparam int unsigned AXIS_Y = 1;
    localparam int unsigned AXIS_Z = 2;

    // LSB position of an axis field of the given width inside a packed bus
    function automatic int unsigned axis_lsb(input int unsigned axis,
                                             input int unsigned num_axes,
                                             input int unsigned width);
        return (num_axes - 1 - axis) * width;
    endfunction

endpackage

// File: rtl/box_axis_normalize.sv
// One axis of the box pipeline: compare/swap on the stage-1 values and
// extent subtraction on the stage-2 values. Purely combinational; the
// registers live in the parent pipeline stages.
module box_axis_normalize #(
    parameter int unsigned COORD_W = 16,
    parameter bit          SIGNED  = 1'b1
) (
    input  logic [COORD_W-1:0] cmp_min,
    input  logic [COORD_W-1:0] cmp_max,
    output logic [COORD_W-1:0] norm_min,
    output logic [COORD_W-1:0] norm_max,
    output logic               swapped,
    input  logic [COORD_W-1:0] sub_min,
    input  logic [COORD_W-1:0] sub_max,
    output logic [COORD_W:0]   size
);

    // Detect an inverted axis; equal values are left alone
    always_comb begin
        swapped = 1'b0;
        if (SIGNED) begin
            swapped = $signed(cmp_min) > $signed(cmp_max);
        end else begin
            swapped = cmp_min > cmp_max;
        end
    end

    // Route the corner values so min <= max
    always_comb begin
        norm_min = cmp_min;
        norm_max = cmp_max;
        if (swapped) begin
            norm_min = cmp_max;
            norm_max = cmp_min;
        end
    end

    // One extra bit keeps the full-range difference exact; inputs are
    // already ordered so the result is non-negative
    always_comb begin
        size = '0;
        if (SIGNED) begin
            size = {sub_max[COORD_W-1], sub_max} - {sub_min[COORD_W-1], sub_min};
        end else begin
            size = {1'b0, sub_max} - {1'b0, sub_min};
        end
    end

endmodule

// File: rtl/box_stream_unpacker.sv
// Two-stage valid/ready pipeline that normalises packed bounding boxes,
// computes per-axis extents and tracks per-frame box indices.
module box_stream_unpacker
    import box_pkg::*;
#(
    parameter int unsigned COORD_W  = DEFAULT_COORD_W,
    parameter int unsigned NUM_AXES = DEFAULT_NUM_AXES,
    parameter bit          SIGNED   = 1'b1,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [NUM_AXES*COORD_W-1:0]     s_box_min,
    input  logic [NUM_AXES*COORD_W-1:0]     s_box_max,
    input  logic                            s_last,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [NUM_AXES*COORD_W-1:0]     m_min,
    output logic [NUM_AXES*COORD_W-1:0]     m_max,
    output logic [NUM_AXES*(COORD_W+1)-1:0] m_size,
    output logic [NUM_AXES-1:0]             m_swapped,
    output logic                            m_last,
    output logic [CNT_W-1:0]                m_index,
    output logic                            frame_done,
    output logic [CNT_W-1:0]                frame_count,
    output logic                            cnt_ovf
);

    localparam int unsigned BUS_W = NUM_AXES * COORD_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Stage 1: raw input box
    logic             s1_valid;
    logic [BUS_W-1:0] s1_min;
    logic [BUS_W-1:0] s1_max;
    logic             s1_last;

    // Stage 2: normalised box
    logic                s2_valid;
    logic [BUS_W-1:0]    s2_min;
    logic [BUS_W-1:0]    s2_max;
    logic [NUM_AXES-1:0] s2_swapped;
    logic                s2_last;

    // Combinational results of the per-axis compare on stage 1
    logic [BUS_W-1:0]    n_min;
    logic [BUS_W-1:0]    n_max;
    logic [NUM_AXES-1:0] n_swapped;

    logic             s2_advance;
    logic             s_fire;
    logic             m_fire;
    logic [CNT_W-1:0] idx_cnt;
    logic [CNT_W-1:0] idx_sat_inc;

    assign s2_advance = !s2_valid || m_ready;
    assign s_ready    = !s1_valid || s2_advance;
    assign s_fire     = s_valid && s_ready;
    assign m_fire     = s2_valid && m_ready;

    assign idx_sat_inc = (idx_cnt == CNT_MAX) ? idx_cnt : idx_cnt + 1'b1;

    for (genvar a = 0; a < NUM_AXES; a++) begin : g_axis
        localparam int unsigned CL = axis_lsb(a, NUM_AXES, COORD_W);
        localparam int unsigned SL = axis_lsb(a, NUM_AXES, COORD_W + 1);

        box_axis_normalize #(
            .COORD_W (COORD_W),
            .SIGNED  (SIGNED)
        ) u_norm (
            .cmp_min  (s1_min[CL +: COORD_W]),
            .cmp_max  (s1_max[CL +: COORD_W]),
            .norm_min (n_min[CL +: COORD_W]),
            .norm_max (n_max[CL +: COORD_W]),
            .swapped  (n_swapped[NUM_AXES-1-a]),
            .sub_min  (s2_min[CL +: COORD_W]),
            .sub_max  (s2_max[CL +: COORD_W]),
            .size     (m_size[SL +: COORD_W+1])
        );
    end

    // Stage valid flags; S1 empties into S2 whenever s_ready is high
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s_ready) begin
                s1_valid <= s_valid;
            end
            if (s2_advance) begin
                s2_valid <= s1_valid;
            end
        end
    end

    // Stage data registers; no reset needed since valids gate them
    always_ff @(posedge clk) begin
        if (s_fire) begin
            s1_min  <= s_box_min;
            s1_max  <= s_box_max;
            s1_last <= s_last;
        end
        if (s2_advance && s1_valid) begin
            s2_min     <= n_min;
            s2_max     <= n_max;
            s2_swapped <= n_swapped;
            s2_last    <= s1_last;
        end
    end

    // Per-frame index, completed-frame count and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_cnt     <= '0;
            frame_count <= '0;
            frame_done  <= 1'b0;
            cnt_ovf     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (m_fire) begin
                // Transfer at the saturated index means the frame has one box too many
                if (idx_cnt == CNT_MAX) begin
                    cnt_ovf <= 1'b1;
                end
                if (s2_last) begin
                    frame_count <= idx_sat_inc;
                    idx_cnt     <= '0;
                    frame_done  <= 1'b1;
                end else begin
                    idx_cnt <= idx_sat_inc;
                end
            end
        end
    end

    assign m_valid   = s2_valid;
    assign m_min     = s2_min;
    assign m_max     = s2_max;
    assign m_swapped = s2_swapped;
    assign m_last    = s2_last;
    assign m_index   = idx_cnt;

endmodule

// File: tb/tb_box_stream_unpacker.sv
// Bench for box_stream_unpacker: a signed/8-bit-count instance and an
// unsigned/2-bit-count instance share one input stream and are checked
// against an arithmetic reference model.
module tb_box_stream_unpacker;
    import box_pkg::*;

    typedef struct {
        logic [47:0] mn;
        logic [47:0] mx;
        logic [50:0] sz;
        logic [2:0]  sw;
        logic        last;
    } box_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        m_ready = 1'b1;
    logic [47:0] s_box_min = '0;
    logic [47:0] s_box_max = '0;

    logic        a_s_ready, a_m_valid, a_m_last, a_frame_done, a_cnt_ovf;
    logic [47:0] a_m_min, a_m_max;
    logic [50:0] a_m_size;
    logic [2:0]  a_m_swapped;
    logic [7:0]  a_m_index, a_frame_count;

    logic        b_s_ready, b_m_valid, b_m_last, b_frame_done, b_cnt_ovf;
    logic [47:0] b_m_min, b_m_max;
    logic [50:0] b_m_size;
    logic [2:0]  b_m_swapped;
    logic [1:0]  b_m_index, b_frame_count;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;
    logic last_fire = 1'b0;

    box_t q0[$];
    box_t q1[$];
    int   pos[2];
    int   fc_exp[2];
    bit   done_exp[2];
    bit   ovf_exp[2];
    int   done_seen[2];
    bit   sgn[2] = '{1'b1, 1'b0};
    int   cmax[2] = '{255, 3};
    string nm[2] = '{"A", "B"};

    box_stream_unpacker #(
        .COORD_W(16), .NUM_AXES(3), .SIGNED(1'b1), .CNT_W(8)
    ) dut_a (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_box_min(s_box_min), .s_box_max(s_box_max), .s_last(s_last),
        .m_valid(a_m_valid), .m_ready(m_ready), .m_min(a_m_min), .m_max(a_m_max),
        .m_size(a_m_size), .m_swapped(a_m_swapped), .m_last(a_m_last),
        .m_index(a_m_index), .frame_done(a_frame_done),
        .frame_count(a_frame_count), .cnt_ovf(a_cnt_ovf)
    );

    box_stream_unpacker #(
        .COORD_W(16), .NUM_AXES(3), .SIGNED(1'b0), .CNT_W(2)
    ) dut_b (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(b_s_ready),
        .s_box_min(s_box_min), .s_box_max(s_box_max), .s_last(s_last),
        .m_valid(b_m_valid), .m_ready(m_ready), .m_min(b_m_min), .m_max(b_m_max),
        .m_size(b_m_size), .m_swapped(b_m_swapped), .m_last(b_m_last),
        .m_index(b_m_index), .frame_done(b_frame_done),
        .frame_count(b_frame_count), .cnt_ovf(b_cnt_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] pack3(input int x, input int y, input int z);
        return {16'(x), 16'(y), 16'(z)};
    endfunction

    // Reference: order each axis numerically, extent is hi - lo
    function automatic box_t ref_box(input logic [47:0] mn, input logic [47:0] mx,
                                     input bit sg, input logic last);
        box_t r;
        longint lo, hi, t, diff;
        logic [15:0] fa, fb;
        r.mn = '0; r.mx = '0; r.sz = '0; r.sw = '0; r.last = last;
        for (int a = 0; a < 3; a++) begin
            fa = mn[(2-a)*16 +: 16];
            fb = mx[(2-a)*16 +: 16];
            lo = sg ? longint'($signed(fa)) : longint'(fa);
            hi = sg ? longint'($signed(fb)) : longint'(fb);
            if (lo > hi) begin
                t = lo; lo = hi; hi = t;
                r.sw[2-a] = 1'b1;
            end
            diff = hi - lo;
            r.mn[(2-a)*16 +: 16] = lo[15:0];
            r.mx[(2-a)*16 +: 16] = hi[15:0];
            r.sz[(2-a)*17 +: 17] = diff[16:0];
        end
        return r;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic box_t qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic reset_model();
        q0.delete();
        q1.delete();
        for (int d = 0; d < 2; d++) begin
            pos[d] = 0; fc_exp[d] = 0; done_exp[d] = 0; ovf_exp[d] = 0; done_seen[d] = 0;
        end
    endtask

    task automatic mon(input int d, input logic sready, input logic mv,
                       input logic [47:0] mmin, input logic [47:0] mmax,
                       input logic [50:0] msz, input logic [2:0] msw, input logic mlast,
                       input logic [7:0] midx, input logic fd, input logic [7:0] fc,
                       input logic ovf);
        int held;
        box_t b;
        held = qsize(d);
        check({nm[d], " s_ready"}, sready, (held < 2) || m_ready);
        check({nm[d], " frame_done"}, fd, done_exp[d]);
        check({nm[d], " frame_count"}, fc, fc_exp[d]);
        check({nm[d], " cnt_ovf"}, ovf, ovf_exp[d]);
        if (fd === 1'b1) done_seen[d]++;
        done_exp[d] = 0;
        if (mv === 1'b1) begin
            check({nm[d], " m_valid with box pending"}, held > 0, 1);
            if (held > 0) begin
                b = qfront(d);
                check({nm[d], " m_min"}, mmin, b.mn);
                check({nm[d], " m_max"}, mmax, b.mx);
                check({nm[d], " m_size"}, msz, b.sz);
                check({nm[d], " m_swapped"}, msw, b.sw);
                check({nm[d], " m_last"}, mlast, b.last);
                check({nm[d], " m_index"}, midx, (pos[d] > cmax[d]) ? cmax[d] : pos[d]);
                if (m_ready) begin
                    if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                    if (pos[d] >= cmax[d]) ovf_exp[d] = 1;
                    if (b.last) begin
                        fc_exp[d] = (pos[d] + 1 > cmax[d]) ? cmax[d] : pos[d] + 1;
                        done_exp[d] = 1;
                        pos[d] = 0;
                    end else begin
                        pos[d]++;
                    end
                end
            end
        end
        if (sready === 1'b1 && s_valid) begin
            if (d == 0) q0.push_back(ref_box(s_box_min, s_box_max, sgn[d], s_last));
            else        q1.push_back(ref_box(s_box_min, s_box_max, sgn[d], s_last));
        end
    endtask

    // Sample on the falling edge, then drive the next m_ready after the rising edge
    task automatic tick();
        @(negedge clk);
        last_fire = s_valid && a_s_ready;
        if (rst) begin
            reset_model();
        end else begin
            mon(0, a_s_ready, a_m_valid, a_m_min, a_m_max, a_m_size, a_m_swapped, a_m_last,
                a_m_index, a_frame_done, a_frame_count, a_cnt_ovf);
            mon(1, b_s_ready, b_m_valid, b_m_min, b_m_max, b_m_size, b_m_swapped, b_m_last,
                {6'd0, b_m_index}, b_frame_done, {6'd0, b_frame_count}, b_cnt_ovf);
        end
        cyc++;
        @(posedge clk);
        #1;
        case (mode)
            0: m_ready = 1'b1;
            1: m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            default: m_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic send_box(input logic [47:0] mn, input logic [47:0] mx, input logic last);
        s_box_min = mn;
        s_box_max = mx;
        s_last = last;
        s_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (last_fire) break;
        end
        check("send accepted", last_fire, 1'b1);
        s_valid = 1'b0;
    endtask

    task automatic drain();
        s_valid = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (qsize(0) == 0 && qsize(1) == 0) break;
            tick();
        end
        check("drain complete", qsize(0) + qsize(1), 0);
        tick();
    endtask

    task automatic do_reset();
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int xl;
        xl = int'(axis_lsb(AXIS_X, 3, 16));

        // Reset state
        mode = 0;
        do_reset();
        check("reset s_ready", a_s_ready, 1'b1);
        check("reset m_valid", a_m_valid, 1'b0);
        check("reset frame_count", a_frame_count, 0);
        check("reset frame_done", a_frame_done, 1'b0);
        check("reset cnt_ovf", a_cnt_ovf, 1'b0);

        // Normal signed box and two-edge latency
        send_box(pack3(-5, 0, 10), pack3(20, 3, 12), 1'b0);
        check("latency m_valid after one edge", a_m_valid, 1'b0);
        tick();
        check("latency m_valid after two edges", a_m_valid, 1'b1);
        check("normal size", a_m_size, {17'd25, 17'd3, 17'd2});
        check("normal swapped", a_m_swapped, 3'b000);
        check("normal index", a_m_index, 0);
        tick();

        // Inverted x axis
        send_box(pack3(100, 1, 1), pack3(40, 2, 2), 1'b0);
        tick();
        check("inverted min.x", a_m_min[xl +: 16], 16'd40);
        check("inverted max.x", a_m_max[xl +: 16], 16'd100);
        check("inverted size.x", a_m_size[int'(axis_lsb(AXIS_X, 3, 17)) +: 17], 17'd60);
        check("inverted swapped", a_m_swapped, 3'b100);
        tick();

        // Full-range x: signed keeps order, unsigned swaps
        send_box({16'h8000, 32'd0}, {16'h7FFF, 32'd0}, 1'b1);
        tick();
        check("signed swapped", a_m_swapped, 3'b000);
        check("signed size.x", a_m_size[50:34], 17'h0FFFF);
        check("unsigned swapped", b_m_swapped, 3'b100);
        check("unsigned size.x", b_m_size[50:34], 17'h00001);
        drain();

        // Backpressure with m_ready pattern 1,0,0,1
        do_reset();
        mode = 1;
        for (int i = 0; i < 5; i++) begin
            send_box(pack3(i, -i, 7 * i), pack3(3 - i, i, 100 - i), 1'(i == 4));
        end
        drain();

        // Frame accounting: 3-box frame then 1-box frame
        do_reset();
        mode = 0;
        for (int i = 0; i < 3; i++) send_box(pack3(i, i, i), pack3(9, 9, 9), 1'(i == 2));
        drain();
        check("frame_count after 3-box frame", a_frame_count, 8'd3);
        send_box(pack3(1, 2, 3), pack3(4, 5, 6), 1'b1);
        drain();
        check("frame_count after 1-box frame", a_frame_count, 8'd1);
        check("frame_done pulses", done_seen[0], 2);

        // Randomised stream with random backpressure and frame ends
        mode = 2;
        for (int i = 0; i < 40; i++) begin
            send_box({16'($urandom), 16'($urandom), 16'($urandom)},
                     {16'($urandom), 16'($urandom), 16'($urandom)},
                     1'($urandom_range(0, 4) == 0));
        end
        drain();

        // Overflow on the 2-bit counter instance
        do_reset();
        mode = 0;
        for (int i = 0; i < 6; i++) send_box(pack3(i, 0, 0), pack3(10, 1, 1), 1'(i == 5));
        drain();
        check("ovf frame_count B", b_frame_count, 2'd3);
        check("ovf cnt_ovf B", b_cnt_ovf, 1'b1);
        check("ovf frame_count A", a_frame_count, 8'd6);
        check("ovf cnt_ovf A", a_cnt_ovf, 1'b0);

        // Reset mid-frame, then first box restarts at index 0
        send_box(pack3(1, 1, 1), pack3(2, 2, 2), 1'b0);
        send_box(pack3(1, 1, 1), pack3(2, 2, 2), 1'b0);
        do_reset();
        check("mid-frame reset cnt_ovf B", b_cnt_ovf, 1'b0);
        check("mid-frame reset m_valid", a_m_valid, 1'b0);
        send_box(pack3(5, 5, 5), pack3(6, 6, 6), 1'b1);
        tick();
        check("post-reset m_valid", b_m_valid, 1'b1);
        check("post-reset index B", b_m_index, 2'd0);
        drain();
        check("post-reset frame_count B", b_frame_count, 2'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
